hazard_ctrl: RTL and testbench

- Pipeline control block that produces the write-enable and flush controls consumed by the PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers.
- Detects load-use hazards between ID and EX, taken branches resolved in EX, and jumps decoded in ID.
- Freezes the whole pipeline while a data-memory or peripheral access waits for ready.
- Contains an FSM with a wait-timeout watchdog and saturating stall/flush performance counters.

---
 rtl/hazard_ctrl_pkg.sv | 27 ++
 rtl/hazard_ctrl_sat_counter.sv | 20 ++
 rtl/hazard_ctrl.sv | 140 ++++++++++++++
 tb/tb_hazard_ctrl.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
// Control bundle bit order: PC, IF/ID we, IF/ID flush, ID/EX we, ID/EX flush, EX/MEM we, MEM/WB flush.
package hazard_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    ERR      = 2'd2
  } state_t;

  localparam logic [4:0] REG_ZERO = 5'd0;

  typedef struct packed {
    logic pc_w;
    logic ifid_w;
    logic ifid_f;
    logic idex_w;
    logic idex_f;
    logic exmem_w;
    logic memwb_f;
  } ctl_t;

  localparam ctl_t CTL_NORMAL = 7'b1101010;
  localparam ctl_t CTL_FREEZE = 7'b0000001;
  localparam ctl_t CTL_RESET  = 7'b0010101;

endpackage

// File: rtl/hazard_ctrl_sat_counter.sv
// Saturating up-counter with asynchronous active-low clear.
// Holds at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stall, branch/jump flush,
// memory-wait freeze with timeout watchdog and performance counters.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int CNT_W       = 32,
  parameter int MEM_TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       ID_rs,
  input  logic [4:0]       ID_rt,
  input  logic             ID_UseRs,
  input  logic             ID_UseRt,
  input  logic             ID_Jump,
  input  logic             EX_MemRead,
  input  logic [4:0]       EX_WriteReg,
  input  logic             EX_BranchTaken,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic             PC_Write,
  output logic             IF_ID_Write,
  output logic             IF_ID_flush,
  output logic             ID_EX_Write,
  output logic             ID_EX_flush,
  output logic             EX_MEM_Write,
  output logic             MEM_WB_flush,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_cycles
);

  localparam int WC_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WC_W-1:0] WC_ONE  = WC_W'(1);
  localparam logic [WC_W-1:0] WC_LAST = WC_W'(MEM_TIMEOUT - 1);

  state_t          r_state;
  state_t          w_nxt;
  logic [WC_W-1:0] r_wait;
  logic [WC_W-1:0] w_wait_nxt;
  logic            r_to;
  logic            w_hit;
  logic            w_stall;
  ctl_t            w_run;
  ctl_t            w_ctl;
  ctl_t            w_out;

  assign w_hit = EX_MemRead && (EX_WriteReg != REG_ZERO) &&
                 ((ID_UseRs && (ID_rs == EX_WriteReg)) ||
                  (ID_UseRt && (ID_rt == EX_WriteReg)));

  assign w_stall = mem_req && !mem_ready;

  // Branch beats load-use: the flushed ID instruction never issues.
  always_comb begin
    w_run = CTL_NORMAL;
    if (EX_BranchTaken) begin
      w_run.ifid_f = 1'b1;
      w_run.idex_f = 1'b1;
    end else if (w_hit) begin
      w_run.pc_w   = 1'b0;
      w_run.ifid_w = 1'b0;
      w_run.idex_f = 1'b1;
    end else if (ID_Jump) begin
      w_run.ifid_f = 1'b1;
    end
  end

  always_comb begin
    w_nxt      = r_state;
    w_wait_nxt = r_wait;
    w_ctl      = CTL_FREEZE;
    case (r_state)
      RUN: begin
        if (w_stall) begin
          w_nxt      = MEM_WAIT;
          w_wait_nxt = WC_ONE;
        end else begin
          w_ctl = w_run;
        end
      end
      MEM_WAIT: begin
        if (mem_ready) begin
          w_ctl      = w_run;
          w_nxt      = RUN;
          w_wait_nxt = '0;
        end else if (r_wait == WC_LAST) begin
          w_nxt = ERR;
        end else begin
          w_wait_nxt = r_wait + WC_ONE;
        end
      end
      ERR: begin
        w_nxt = ERR;
      end
      default: begin
        w_nxt      = RUN;
        w_wait_nxt = '0;
      end
    endcase
  end

  assign w_out = reset ? w_ctl : CTL_RESET;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= RUN;
      r_wait  <= '0;
      r_to    <= 1'b0;
    end else begin
      r_state <= w_nxt;
      r_wait  <= w_wait_nxt;
      r_to    <= r_to | (w_nxt == ERR);
    end
  end

  assign PC_Write     = w_out.pc_w;
  assign IF_ID_Write  = w_out.ifid_w;
  assign IF_ID_flush  = w_out.ifid_f;
  assign ID_EX_Write  = w_out.idex_w;
  assign ID_EX_flush  = w_out.idex_f;
  assign EX_MEM_Write = w_out.exmem_w;
  assign MEM_WB_flush = w_out.memwb_f;
  assign mem_timeout  = r_to;

  sat_counter #(.W(CNT_W)) u_stall (
    .clk   (clk),
    .reset (reset),
    .inc   (!w_out.pc_w),
    .count (stall_cycles)
  );

  sat_counter #(.W(CNT_W)) u_flush (
    .clk   (clk),
    .reset (reset),
    .inc   (w_out.ifid_f | w_out.idex_f),
    .count (flush_cycles)
  );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl with narrow counters and short timeout.
// Control vector order: PC, IF/ID we, IF/ID flush, ID/EX we, ID/EX flush, EX/MEM we, MEM/WB flush.
module tb_hazard_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] ID_rs, ID_rt, EX_WriteReg;
  logic       ID_UseRs, ID_UseRt, ID_Jump;
  logic       EX_MemRead, EX_BranchTaken;
  logic       mem_req, mem_ready;
  logic       PC_Write, IF_ID_Write, IF_ID_flush;
  logic       ID_EX_Write, ID_EX_flush, EX_MEM_Write;
  logic       MEM_WB_flush, mem_timeout;
  logic [2:0] stall_cycles, flush_cycles;
  logic [6:0] ctl;

  int total = 0;
  int bad   = 0;

  localparam logic [6:0] NORM = 7'b1101010;
  localparam logic [6:0] FRZ  = 7'b0000001;
  localparam logic [6:0] RST  = 7'b0010101;
  localparam logic [6:0] LU   = 7'b0001110;
  localparam logic [6:0] BR   = 7'b1111110;
  localparam logic [6:0] JMP  = 7'b1111010;

  assign ctl = {PC_Write, IF_ID_Write, IF_ID_flush, ID_EX_Write,
                ID_EX_flush, EX_MEM_Write, MEM_WB_flush};

  hazard_ctrl #(.CNT_W(3), .MEM_TIMEOUT(4)) dut (
    .clk            (clk),
    .reset          (reset),
    .ID_rs          (ID_rs),
    .ID_rt          (ID_rt),
    .ID_UseRs       (ID_UseRs),
    .ID_UseRt       (ID_UseRt),
    .ID_Jump        (ID_Jump),
    .EX_MemRead     (EX_MemRead),
    .EX_WriteReg    (EX_WriteReg),
    .EX_BranchTaken (EX_BranchTaken),
    .mem_req        (mem_req),
    .mem_ready      (mem_ready),
    .PC_Write       (PC_Write),
    .IF_ID_Write    (IF_ID_Write),
    .IF_ID_flush    (IF_ID_flush),
    .ID_EX_Write    (ID_EX_Write),
    .ID_EX_flush    (ID_EX_flush),
    .EX_MEM_Write   (EX_MEM_Write),
    .MEM_WB_flush   (MEM_WB_flush),
    .mem_timeout    (mem_timeout),
    .stall_cycles   (stall_cycles),
    .flush_cycles   (flush_cycles)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    ID_rs = 5'd0; ID_rt = 5'd0; EX_WriteReg = 5'd0;
    ID_UseRs = 1'b0; ID_UseRt = 1'b0; ID_Jump = 1'b0;
    EX_MemRead = 1'b0; EX_BranchTaken = 1'b0;
    mem_req = 1'b0; mem_ready = 1'b0;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_rst();
    idle();
    reset = 1'b0;
    #1;
    reset = 1'b1;
    #1;
  endtask

  task automatic set_lu();
    EX_MemRead = 1'b1; EX_WriteReg = 5'd8;
    ID_rs = 5'd8; ID_UseRs = 1'b1;
  endtask

  initial begin
    idle();
    reset = 1'b0;
    #2;
    chk("rst_ctl", 32'(ctl), 32'(RST));
    chk("rst_to", 32'(mem_timeout), 0);
    chk("rst_stall", 32'(stall_cycles), 0);
    chk("rst_flush", 32'(flush_cycles), 0);
    cyc();
    chk("rst_hold_ctl", 32'(ctl), 32'(RST));
    reset = 1'b1;
    #1;
    chk("run_norm", 32'(ctl), 32'(NORM));

    set_lu();
    #1;
    chk("lu_ctl", 32'(ctl), 32'(LU));
    cyc();
    chk("lu_stall", 32'(stall_cycles), 1);
    chk("lu_flush", 32'(flush_cycles), 1);
    EX_MemRead = 1'b0;
    #1;
    chk("lu_bubble_ctl", 32'(ctl), 32'(NORM));
    cyc();
    chk("lu_once_stall", 32'(stall_cycles), 1);

    set_lu();
    EX_WriteReg = 5'd0; ID_rs = 5'd0;
    #1;
    chk("lu_r0_ctl", 32'(ctl), 32'(NORM));
    cyc();
    idle();
    EX_MemRead = 1'b1; EX_WriteReg = 5'd8;
    ID_rt = 5'd8; ID_UseRt = 1'b0; ID_rs = 5'd3; ID_UseRs = 1'b1;
    #1;
    chk("lu_nouse_ctl", 32'(ctl), 32'(NORM));
    cyc();
    idle();
    ID_Jump = 1'b1;
    #1;
    chk("jmp_ctl", 32'(ctl), 32'(JMP));
    cyc();
    chk("jmp_stall", 32'(stall_cycles), 1);
    chk("jmp_flush", 32'(flush_cycles), 2);

    pulse_rst();
    set_lu();
    EX_BranchTaken = 1'b1;
    #1;
    chk("br_lu_ctl", 32'(ctl), 32'(BR));
    cyc();
    chk("br_stall", 32'(stall_cycles), 0);
    chk("br_flush", 32'(flush_cycles), 1);

    pulse_rst();
    EX_BranchTaken = 1'b1; mem_req = 1'b1; mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk($sformatf("wait_frz%0d", i), 32'(ctl), 32'(FRZ));
      cyc();
    end
    mem_ready = 1'b1;
    #1;
    chk("wait_ready_ctl", 32'(ctl), 32'(BR));
    cyc();
    chk("wait_stall", 32'(stall_cycles), 3);
    chk("wait_flush", 32'(flush_cycles), 1);
    idle();
    #1;
    chk("wait_back_run", 32'(ctl), 32'(NORM));
    chk("wait_no_to", 32'(mem_timeout), 0);

    pulse_rst();
    mem_req = 1'b1; mem_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk($sformatf("to_frz%0d", i), 32'(ctl), 32'(FRZ));
      chk($sformatf("to_flag%0d", i), 32'(mem_timeout), 0);
      cyc();
    end
    chk("to_set", 32'(mem_timeout), 1);
    mem_ready = 1'b1;
    #1;
    chk("err_frz", 32'(ctl), 32'(FRZ));
    cyc();
    chk("err_sticky", 32'(mem_timeout), 1);
    chk("err_stall", 32'(stall_cycles), 5);
    reset = 1'b0;
    #1;
    chk("err_rst_to", 32'(mem_timeout), 0);
    chk("err_rst_ctl", 32'(ctl), 32'(RST));
    reset = 1'b1;
    idle();
    #1;
    chk("err_exit_run", 32'(ctl), 32'(NORM));

    pulse_rst();
    set_lu();
    for (int i = 0; i < 10; i++) cyc();
    chk("sat_stall", 32'(stall_cycles), 7);
    chk("sat_flush", 32'(flush_cycles), 7);
    idle();
    mem_req = 1'b1; mem_ready = 1'b0;
    cyc();
    cyc();
    #2;
    reset = 1'b0;
    #1;
    chk("async_stall", 32'(stall_cycles), 0);
    chk("async_flush", 32'(flush_cycles), 0);
    chk("async_ctl", 32'(ctl), 32'(RST));
    reset = 1'b1;
    idle();
    #1;
    chk("async_run", 32'(ctl), 32'(NORM));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
